// File: rtl/serial_8bit_adder.sv
// -----------------------------------------------------------------------------
// serial_8bit_adder
//
// Bit-serial ripple adder with a valid/ready handshake on each side. An
// accepted operand set is added one bit per clock, LSB first, through a single
// full adder. After WIDTH compute cycles the result is presented until the
// consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set a/b/cin is valid
//   in_ready   block can accept an operand set (IDLE only)
//   a, b       addends, unsigned or two's complement
//   cin        carry-in
//   out_valid  sum/cout/ovf hold a fresh result
//   out_ready  consumer accepts the result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow of the addition
//   busy       high while computing or holding a result
//   op_count   results handed off since reset, wraps
// -----------------------------------------------------------------------------
module serial_8bit_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH-1.
    localparam int              BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    state_t           state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh;     // operands, shifted right each CALC edge
    logic [WIDTH-1:0] res_sh;         // sum bits enter at the MSB side
    logic             carry_q;
    logic [BW-1:0]    bit_cnt;
    logic             a_msb, b_msb;   // original sign bits for overflow

    logic             accept;
    logic             handoff;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    // ------------------------------------------------------------------
    // Single full-adder slice working on the bit-0 positions.
    // ------------------------------------------------------------------
    always_comb begin
        s_bit    = a_sh[0] ^ b_sh[0] ^ carry_q;
        c_next   = (a_sh[0] & b_sh[0]) | (carry_q & (a_sh[0] ^ b_sh[0]));
        res_next = (res_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        last_bit = (bit_cnt == LAST_BIT);
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        handoff   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    handoff = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Operands are only sampled on the accepting edge, so input
    // activity during CALC/DONE cannot disturb the result in progress.
    // ------------------------------------------------------------------
    // NOTE: the shift registers are reset along with everything else; they are
    // a handful of flops, not a memory array, and reset keeps them clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            bit_cnt <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            res_sh  <= '0;
            carry_q <= cin;
            bit_cnt <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
        end else if (state_q == CALC) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= c_next;
            bit_cnt <= bit_cnt + BW'(1);
            // Final edge: publish the result. s_bit is the final sum MSB here.
            if (last_bit) begin
                sum  <= res_next;
                cout <= c_next;
                ovf  <= (a_msb == b_msb) && (s_bit != a_msb);
            end
        end
    end

    // ------------------------------------------------------------------
    // Completed-operation counter; wraps naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          op_count <= '0;
        else if (handoff) op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_serial_8bit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_8bit_adder
//
// Directed vector table (including a backpressure entry), an operand-noise
// sequence, a mid-CALC reset sequence and a random run against an a+b+cin
// reference. Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_8bit_adder;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    serial_8bit_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_ops = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         stall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for in_ready, present operands for one edge,
    // wait for the result, optionally hold out_ready low, then hand off.
    task automatic txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [7:0] esum, input logic ecout, input logic eovf,
                       input int stall, input bit noise, input string tag);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb_v;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                cin      = ~cin;
                in_valid = ~in_valid;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(WIDTH));
        check({tag, " sum"},  32'(sum),  32'(esum));
        check({tag, " cout"}, 32'(cout), 32'(ecout));
        check({tag, " ovf"},  32'(ovf),  32'(eovf));
        for (int i = 0; i < stall; i++) begin
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall in_ready"},  32'(in_ready),  32'd0);
            check({tag, " stall sum"},  32'(sum),  32'(esum));
            check({tag, " stall cout"}, 32'(cout), 32'(ecout));
            check({tag, " stall ovf"},  32'(ovf),  32'(eovf));
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp_ops++;
        check({tag, " out_valid_after_handoff"}, 32'(out_valid), 32'd0);
        check({tag, " busy_after_handoff"},      32'(busy),      32'd0);
        check({tag, " op_count"},                32'(op_count),  32'(exp_ops));
        check({tag, " sum_retained"},            32'(sum),       32'(esum));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, ec, eo;
        logic [8:0] full;
        int         st;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0};
        vecs[6] = '{8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1, 5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset sum",       32'(sum),       32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        check("reset op_count",  32'(op_count),  32'd0);

        // Directed table; the first entry is accepted on the first edge after
        // reset release and must leave op_count at 1.
        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                vecs[i].ovf, vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
        end

        // Operands and in_valid thrash during CALC; result follows latched set.
        txn(8'h0A, 8'h0B, 1'b0, 8'h15, 1'b0, 1'b0, 0, 1'b1, "noise");

        // Reset three cycles into CALC aborts the operation.
        while (!in_ready) tick();
        a        = 8'h55;
        b        = 8'h22;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        exp_ops = '0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy",      32'(busy),      32'd0);
        check("midrst sum",       32'(sum),       32'd0);
        check("midrst cout",      32'(cout),      32'd0);
        check("midrst ovf",       32'(ovf),       32'd0);
        check("midrst op_count",  32'(op_count),  32'd0);
        tick();
        rst = 1'b0;
        txn(8'h0F, 8'h0F, 1'b1, 8'h1F, 1'b0, 1'b0, 0, 1'b0, "post_rst");

        // Random run against a behavioural a+b+cin reference.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            es   = full[7:0];
            ec   = full[8];
            eo   = (ra[7] == rb[7]) && (es[7] != ra[7]);
            st   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            txn(ra, rb, rc, es, ec, eo, st, 1'b0, $sformatf("rnd%0d", i));
        end
        check("final op_count", 32'(op_count), 32'd1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
